// File: rtl/voice_sched_if.sv
// Bus between the voice scheduler and its oscillators, combiner and output stage.
// The slave modport is the scheduler's view; the master modport drives it.
interface voice_sched_if;
   logic       en;
   logic       key1_on;
   logic       key2_on;
   logic       osc1_valid;
   logic       osc2_valid;
   logic [7:0] osc1_sample;
   logic [7:0] osc2_sample;
   logic       comb_ready;
   logic [7:0] comb_waveform;
   logic       err_clr;
   logic       osc1_req;
   logic       osc2_req;
   logic [7:0] sample1;
   logic [7:0] sample2;
   logic       done1;
   logic       done2;
   logic       multi;
   logic [7:0] pcm_out;
   logic       pcm_valid;
   logic       osc_err;
   logic       comb_err;
   logic       overrun;

   modport slave (
      input  en, key1_on, key2_on, osc1_valid, osc2_valid, osc1_sample, osc2_sample,
             comb_ready, comb_waveform, err_clr,
      output osc1_req, osc2_req, sample1, sample2, done1, done2, multi,
             pcm_out, pcm_valid, osc_err, comb_err, overrun
   );

   modport master (
      output en, key1_on, key2_on, osc1_valid, osc2_valid, osc1_sample, osc2_sample,
             comb_ready, comb_waveform, err_clr,
      input  osc1_req, osc2_req, sample1, sample2, done1, done2, multi,
             pcm_out, pcm_valid, osc_err, comb_err, overrun
   );
endinterface

// File: rtl/voice_sched.sv
// Sample-rate scheduler: gathers one sample per active voice each tick, hands
// them to the combiner and emits one PCM sample, falling back to midscale 128.
module voice_sched #(
   parameter int DIV     = 250,
   parameter int TIMEOUT = 15
) (
   input  logic         clk,
   input  logic         rst,
   voice_sched_if.slave bus
);

   localparam int CW = $clog2(DIV);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_OSC, COMB} state_t;

   state_t         state;
   logic [CW-1:0]  tick_cnt;
   logic [TW-1:0]  tcnt;
   logic           act1, act2;
   logic           got1, got2;
   logic           tick;
   logic           cap1, cap2;
   logic           have1, have2;
   logic           all_have;
   logic           expired;

   assign tick     = bus.en && (tick_cnt == CW'(DIV - 1));
   assign cap1     = (state == WAIT_OSC) && act1 && bus.osc1_valid;
   assign cap2     = (state == WAIT_OSC) && act2 && bus.osc2_valid;
   assign have1    = got1 || cap1;
   assign have2    = got2 || cap2;
   assign all_have = (!act1 || have1) && (!act2 || have2);
   assign expired  = (tcnt == TW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst || !bus.en || tick_cnt == CW'(DIV - 1))
         tick_cnt <= '0;
      else
         tick_cnt <= tick_cnt + 1'b1;
   end

   // Sticky flags: the clear comes first so a same-cycle set below wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         tcnt          <= '0;
         act1          <= 1'b0;
         act2          <= 1'b0;
         got1          <= 1'b0;
         got2          <= 1'b0;
         bus.osc1_req  <= 1'b0;
         bus.osc2_req  <= 1'b0;
         bus.sample1   <= 8'd0;
         bus.sample2   <= 8'd0;
         bus.done1     <= 1'b0;
         bus.done2     <= 1'b0;
         bus.multi     <= 1'b0;
         bus.pcm_out   <= 8'd128;
         bus.pcm_valid <= 1'b0;
         bus.osc_err   <= 1'b0;
         bus.comb_err  <= 1'b0;
         bus.overrun   <= 1'b0;
      end else begin
         bus.pcm_valid <= 1'b0;
         bus.osc1_req  <= 1'b0;
         bus.osc2_req  <= 1'b0;
         if (bus.err_clr) begin
            bus.osc_err  <= 1'b0;
            bus.comb_err <= 1'b0;
            bus.overrun  <= 1'b0;
         end
         if (tick && state != IDLE)
            bus.overrun <= 1'b1;

         case (state)
            IDLE: begin
               if (tick) begin
                  act1 <= bus.key1_on;
                  act2 <= bus.key2_on;
                  if (!bus.key1_on && !bus.key2_on) begin
                     bus.pcm_out   <= 8'd128;
                     bus.pcm_valid <= 1'b1;
                  end else begin
                     bus.osc1_req <= bus.key1_on;
                     bus.osc2_req <= bus.key2_on;
                     state        <= REQ;
                  end
               end
            end
            REQ: begin
               got1  <= 1'b0;
               got2  <= 1'b0;
               tcnt  <= '0;
               state <= WAIT_OSC;
            end
            WAIT_OSC: begin
               if (cap1) begin
                  bus.sample1 <= bus.osc1_sample;
                  got1        <= 1'b1;
               end
               if (cap2) begin
                  bus.sample2 <= bus.osc2_sample;
                  got2        <= 1'b1;
               end
               // Silent voices feed 0, stalled ones feed midscale.
               if (all_have || expired) begin
                  state     <= COMB;
                  tcnt      <= '0;
                  bus.done1 <= act1;
                  bus.done2 <= act2;
                  bus.multi <= act1 && act2;
                  if (!act1)
                     bus.sample1 <= 8'd0;
                  else if (!have1)
                     bus.sample1 <= 8'd128;
                  if (!act2)
                     bus.sample2 <= 8'd0;
                  else if (!have2)
                     bus.sample2 <= 8'd128;
                  if (!all_have)
                     bus.osc_err <= 1'b1;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            COMB: begin
               if (bus.comb_ready || expired) begin
                  bus.pcm_out   <= bus.comb_ready ? bus.comb_waveform : 8'd128;
                  bus.pcm_valid <= 1'b1;
                  bus.done1     <= 1'b0;
                  bus.done2     <= 1'b0;
                  bus.multi     <= 1'b0;
                  state         <= IDLE;
                  if (!bus.comb_ready)
                     bus.comb_err <= 1'b1;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/voice_sched.md
# voice_sched

Sample-rate scheduler that sequences the two oscillator voices into the `waveform_comb` combiner and delivers one mixed PCM sample per sample tick to the output stage. It divides the system clock into a sample tick and requests a sample from each active oscillator. It then drives the combiner's `sample1`/`sample2`/`done1`/`done2`/`multi` inputs, waits for `ready`, and forwards the combined value. Silence, oscillator stalls and frame overruns are handled without stalling the output rate.

## Interface
- `DIV`, 250: sample tick period in `clk` cycles (≥ 8).
- `TIMEOUT`, 15: max cycles spent in WAIT_OSC or COMB before forced completion.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  tick counter enable.
- `key1_on`, `key2_on`  in  1  voice active flags.
- `osc1_valid`, `osc2_valid`  in  1  oscillator sample-valid pulses.
- `osc1_sample`, `osc2_sample`  in  8  oscillator samples.
- `comb_ready`  in  1  combiner `ready`.
- `comb_waveform`  in  8  combiner output.
- `err_clr`  in  1  clears sticky error flags.
- `osc1_req`, `osc2_req`  out  1  one-cycle sample request.
- `sample1`, `sample2`  out  8  to combiner, registered.
- `done1`, `done2`, `multi`  out  1  to combiner, registered.
- `pcm_out`  out  8  mixed sample.
- `pcm_valid`  out  1  one-cycle strobe.
- `osc_err`, `comb_err`, `overrun`  out  1  sticky flags.

## Operation
- Tick counter behaviour:
  - When `en`=1, it counts 0..DIV-1 and pulses `tick` for one cycle at DIV-1.
  - When `en`=0, it is held at 0 with no tick.
- FSM states: IDLE, REQ, WAIT_OSC, COMB.
- IDLE on `tick`:
  - Latch `act1`/`act2` from the keys.
  - If neither key is set, load `pcm_out`=128 with `pcm_valid`, and stay in IDLE.
  - Otherwise go to REQ.
- REQ (one cycle):
  - `oscN_req`=1 for each active voice.
  - Clear the got flags and the timeout counter, then go to WAIT_OSC.
- WAIT_OSC:
  - On `oscN_valid` with `actN`, capture the sample into `sampleN` and set `gotN`.
  - Valids for inactive voices, or in any other state, are ignored. Both valids in the same cycle are both captured.
  - When every active voice has `got`, go to COMB.
  - On timeout, load 128 into each missing `sampleN`, set `osc_err`, and go to COMB.
- COMB:
  - `doneN`=`actN`, `multi`=`act1&act2`, all held steady.
  - Inactive `sampleN`=0.
  - On `comb_ready`: `pcm_out`=`comb_waveform`, `pcm_valid`=1 next cycle, all `done*`/`multi`=0, go to IDLE.
  - On timeout: `pcm_out`=128, `pcm_valid`, `comb_err`=1, go to IDLE.
- Overrun:
  - A `tick` arriving in any state other than IDLE sets `overrun` and is dropped.
  - The in-flight frame continues.
- Timeout: the counter increments each cycle in WAIT_OSC/COMB. Timeout fires when the counter reaches TIMEOUT without completion.
- Sticky flags: cleared by `err_clr`. A set and a clear in the same cycle leaves the flag set.
- `en` falling mid-frame: the current frame completes normally.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - `pcm_out`=128.
  - All other outputs 0: `sample*`, `done*`, `multi`, `osc*_req`, `pcm_valid`, and all flags.
- Reset mid-frame: IDLE with reset values on the next edge. No `pcm_valid` is emitted.
- Silence path: tick in cycle T → `pcm_valid` in T+1.
- Voiced path, minimum latency:
  - T: tick.
  - T+1: REQ, `osc_req` high.
  - T+2: valid sampled.
  - T+3: COMB, `done` high, `comb_ready` sampled.
  - T+4: `pcm_valid`, state IDLE. A tick at T+4 is accepted.
- All outputs are registered. `pcm_valid` and `osc*_req` are single-cycle pulses.

## Test plan
- Silence: DIV=8, keys 0, `en`=1 → `pcm_valid` every 8 cycles with `pcm_out`=128; `osc*_req`, `done*` never high.
- Single voice:
  - Stimulus: `key1_on`=1; `osc1_sample`=142 valid at T+2; `comb_ready`=1 with `comb_waveform`=142 at T+3.
  - Response: `osc1_req` at T+1 only, `sample1`=142, `done1`=1, `done2`=0, `multi`=0, `pcm_out`=142 with `pcm_valid` at T+4.
- Dual voice:
  - Stimulus: both keys on; `osc1`=203 at T+2, `osc2`=243 at T+4; `comb_waveform`=223.
  - Response: COMB entered at T+5, `multi`=1, `done1`=`done2`=1, `pcm_out`=223 one cycle after `comb_ready`.
- Osc timeout: TIMEOUT=4, `key2_on`=1, `osc2_valid` never asserted → `sample2`=128 in COMB, `osc_err`=1; `err_clr` pulse then clears `osc_err`.
- Overrun: DIV=8, TIMEOUT=15, `comb_ready` held low 10 cycles → `overrun`=1, the next tick is dropped, and the frame completes with the combiner value once `comb_ready` rises.
- Reset mid-frame: assert `rst` while in WAIT_OSC → next cycle all outputs at reset values, `pcm_out`=128, no `pcm_valid`; normal frames resume after release.
